hazard_ctrl: RTL and testbench

Pipeline hazard controller that produces the stall and flush controls consumed by the IF/ID, ID/EX and EX/MEM pipeline registers and by the PC.
- It drives id_ex_flush into the ID/EX register and inspects that register's outputs (ex_rd, ex_mem_read) against the instruction in ID.
- It detects three conditions: load-use hazards, taken branches resolved in EX, and data-memory wait states.
- A small FSM plus counter covers multi-cycle memory waits and fetch-redirect bubbles.

---
 rtl/pipe_pkg.sv | 13 +
 rtl/hazard_lu_detect.sv | 22 ++
 rtl/hazard_ctrl.sv | 152 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: hazard FSM state encodings and register-file addressing.
package pipe_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_REDIRECT = 2'd2
    } hz_state_e;

endpackage

// File: rtl/hazard_lu_detect.sv
// Combinational load-use compare between the load in EX and the source operands of the
// instruction in ID. x0 is hard-wired zero and is never treated as a producer.
module hazard_lu_detect
    import pipe_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    output logic                  lu_hit
);

    logic rs1_match;
    logic rs2_match;

    assign rs1_match = id_uses_rs1 && (ex_rd == id_rs1);
    assign rs2_match = id_uses_rs2 && (ex_rd == id_rs2);
    assign lu_hit    = ex_mem_read && (ex_rd != REG_X0) && (rs1_match || rs2_match);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-wait stalls, taken-branch flushes with redirect bubbles,
// and load-use bubbles. Optional performance counters are enabled with HAZARD_PERF_EN.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned REDIRECT_BUBBLES = 1,
    parameter int unsigned CNT_W            = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  ex_br_taken,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic                  pc_stall,
    output logic                  if_id_stall,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  pipe_stall,
    output logic [1:0]            state_o
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]           perf_lu_cnt,
    output logic [31:0]           perf_br_cnt,
    output logic [31:0]           perf_mw_cnt
`endif
);

    localparam logic [CNT_W-1:0] BUBBLES = CNT_W'(REDIRECT_BUBBLES);

    hz_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lu_hit;
    logic             mem_stall;

    hazard_lu_detect u_lu_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .lu_hit      (lu_hit)
    );

    assign mem_stall = mem_req && !mem_ready;

    always_comb begin
        // NOTE: every output and next-state signal gets a default first so no latch is inferred.
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_stall    = 1'b0;
        if_id_stall = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        pipe_stall  = 1'b0;

        if (mem_stall) begin
            // Freeze everything, including a pending redirect count.
            pipe_stall  = 1'b1;
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            state_d     = ST_MEM_WAIT;
        end else if (ex_br_taken) begin
            // Squash both younger instructions; a load-use stall on ID is moot.
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            if (REDIRECT_BUBBLES > 0) begin
                cnt_d   = BUBBLES;
                state_d = ST_REDIRECT;
            end else begin
                state_d = ST_RUN;
            end
        end else begin
            case (state_q)
                ST_MEM_WAIT: begin
                    state_d = (cnt_q != '0) ? ST_REDIRECT : ST_RUN;
                end
                ST_REDIRECT: begin
                    if_id_flush = 1'b1;
                    if (cnt_q <= CNT_W'(1)) begin
                        cnt_d   = '0;
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    if (lu_hit) begin
                        pc_stall    = 1'b1;
                        if_id_stall = 1'b1;
                        id_ex_flush = 1'b1;
                    end
                end
            endcase
        end

        // NOTE: reset is synchronous, so it is folded into the next-state logic rather than the flop sensitivity.
        state_o = state_q;
        if (!rst) begin
            state_d     = ST_RUN;
            cnt_d       = '0;
            pc_stall    = 1'b0;
            if_id_stall = 1'b0;
            if_id_flush = 1'b0;
            id_ex_flush = 1'b0;
            pipe_stall  = 1'b0;
            state_o     = ST_RUN;
        end
    end

    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    always_ff @(posedge clk) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_lu_q, perf_lu_d;
    logic [31:0] perf_br_q, perf_br_d;
    logic [31:0] perf_mw_q, perf_mw_d;

    // Events are recovered from the gated outputs: only a load-use bubble flushes ID/EX alone.
    always_comb begin
        perf_lu_d = perf_lu_q + {31'd0, id_ex_flush && !if_id_flush};
        perf_br_d = perf_br_q + {31'd0, id_ex_flush && if_id_flush};
        perf_mw_d = perf_mw_q + {31'd0, pipe_stall};
        if (!rst) begin
            perf_lu_d = '0;
            perf_br_d = '0;
            perf_mw_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        perf_lu_q <= perf_lu_d;
        perf_br_q <= perf_br_d;
        perf_mw_q <= perf_mw_d;
    end

    assign perf_lu_cnt = perf_lu_q;
    assign perf_br_cnt = perf_br_q;
    assign perf_mw_cnt = perf_mw_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl (REDIRECT_BUBBLES=2): rule-level model compared every cycle plus
// directed vectors with hand-computed expectations. Perf counters checked under HAZARD_PERF_EN.
module tb_hazard_ctrl;
    localparam int R = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic       id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0;
    logic       ex_mem_read = 1'b0, ex_br_taken = 1'b0;
    logic       mem_req = 1'b0, mem_ready = 1'b0;
    logic       pc_stall, if_id_stall, if_id_flush, id_ex_flush, pipe_stall;
    logic [1:0] state_o;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_lu_cnt, perf_br_cnt, perf_mw_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b1;

    hazard_ctrl #(.REDIRECT_BUBBLES(R), .CNT_W(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .ex_br_taken (ex_br_taken),
        .mem_req     (mem_req),
        .mem_ready   (mem_ready),
        .pc_stall    (pc_stall),
        .if_id_stall (if_id_stall),
        .if_id_flush (if_id_flush),
        .id_ex_flush (id_ex_flush),
        .pipe_stall  (pipe_stall),
        .state_o     (state_o)
`ifdef HAZARD_PERF_EN
        ,
        .perf_lu_cnt (perf_lu_cnt),
        .perf_br_cnt (perf_br_cnt),
        .perf_mw_cnt (perf_mw_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // waiting: a memory wait is in progress; left: redirect bubbles still owed to fetch.
    bit waiting = 1'b0;
    int left    = 0;
    int m_lu = 0, m_br = 0, m_mw = 0;

    always @(negedge clk) begin
        bit stall, lu;
        logic [4:0] exp_o;   // {pc_stall, if_id_stall, if_id_flush, id_ex_flush, pipe_stall}
        logic [1:0] exp_st;
        if (cmp_en) begin
            stall = mem_req && !mem_ready;
            lu = ex_mem_read && ex_rd != 0 &&
                 ((id_uses_rs1 && ex_rd == id_rs1) || (id_uses_rs2 && ex_rd == id_rs2));
            exp_o  = 5'b00000;
            exp_st = !rst ? 2'd0 : waiting ? 2'd1 : (left > 0) ? 2'd2 : 2'd0;
`ifdef HAZARD_PERF_EN
            check("perf_lu", perf_lu_cnt, m_lu);
            check("perf_br", perf_br_cnt, m_br);
            check("perf_mw", perf_mw_cnt, m_mw);
`endif
            if (!rst) begin
                waiting = 0; left = 0; m_lu = 0; m_br = 0; m_mw = 0;
            end else if (stall) begin
                exp_o = 5'b11001; waiting = 1; m_mw++;
            end else if (ex_br_taken) begin
                exp_o = 5'b00110; waiting = 0; left = R; m_br++;
            end else if (waiting) begin
                waiting = 0;
            end else if (left > 0) begin
                exp_o = 5'b00100; left--;
            end else if (lu) begin
                exp_o = 5'b11010; m_lu++;
            end
            check("model_outs", {pc_stall, if_id_stall, if_id_flush, id_ex_flush, pipe_stall}, exp_o);
            check("model_state", state_o, exp_st);
            check("stall_flush_excl", if_id_stall & if_id_flush, 1'b0);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc(input logic r, input logic br, input logic mreq, input logic mrdy,
                       input logic ld, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic u1, input logic u2);
        @(posedge clk);
        #1;
        rst = r; ex_br_taken = br; mem_req = mreq; mem_ready = mrdy;
        ex_mem_read = ld; ex_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
        id_uses_rs1 = u1; id_uses_rs2 = u2;
        #2;
    endtask

    task automatic idle();
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic dchk(input string name, input logic [4:0] exp_o, input logic [1:0] exp_st);
        check({name, "_outs"}, {pc_stall, if_id_stall, if_id_flush, id_ex_flush, pipe_stall}, exp_o);
        check({name, "_state"}, state_o, exp_st);
    endtask

    initial begin
        // Reset held with hazards present: outputs forced low.
        cyc(0, 1, 1, 0, 1, 5, 0, 5, 0, 1);
        dchk("reset_a", 5'b00000, 2'd0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        dchk("reset_b", 5'b00000, 2'd0);
        idle(); dchk("idle", 5'b00000, 2'd0);

        // Load-use on rs2: one bubble, no state change.
        cyc(1, 0, 0, 0, 1, 5, 0, 5, 0, 1); dchk("lu_rs2", 5'b11010, 2'd0);
        idle(); dchk("lu_after", 5'b00000, 2'd0);
        // Load-use on rs1.
        cyc(1, 0, 0, 0, 1, 9, 9, 3, 1, 0); dchk("lu_rs1", 5'b11010, 2'd0);
        // x0 load and unused-operand match are not hazards.
        cyc(1, 0, 0, 0, 1, 0, 0, 0, 1, 1); dchk("lu_x0", 5'b00000, 2'd0);
        cyc(1, 0, 0, 0, 1, 7, 7, 0, 0, 0); dchk("lu_unused", 5'b00000, 2'd0);
        cyc(1, 0, 0, 0, 0, 7, 7, 7, 1, 1); dchk("not_load", 5'b00000, 2'd0);

        // Taken branch: flush, then two redirect bubbles.
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0); dchk("br_c0", 5'b00110, 2'd0);
        idle(); dchk("br_c1", 5'b00100, 2'd2);
        cyc(1, 0, 0, 0, 1, 5, 5, 0, 1, 0); dchk("br_c2_lu_suppr", 5'b00100, 2'd2);
        idle(); dchk("br_c3", 5'b00000, 2'd0);

        // Memory wait for three cycles, released on the ready cycle.
        cyc(1, 0, 1, 0, 0, 0, 0, 0, 0, 0); dchk("mw_c0", 5'b11001, 2'd0);
        cyc(1, 0, 1, 0, 0, 0, 0, 0, 0, 0); dchk("mw_c1", 5'b11001, 2'd1);
        cyc(1, 1, 1, 0, 0, 0, 0, 0, 0, 0); dchk("mw_c2_over_br", 5'b11001, 2'd1);
        cyc(1, 0, 1, 1, 0, 0, 0, 0, 0, 0); dchk("mw_ready", 5'b00000, 2'd1);
        idle(); dchk("mw_after", 5'b00000, 2'd0);

        // Branch and load-use together: branch wins.
        cyc(1, 1, 0, 0, 1, 4, 4, 4, 1, 1); dchk("br_lu", 5'b00110, 2'd0);
        idle(); idle(); idle(); dchk("br_lu_done", 5'b00000, 2'd0);

        // Memory wait inside REDIRECT: count frozen, then remaining bubble issued.
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0); dchk("rw_br", 5'b00110, 2'd0);
        idle(); dchk("rw_bub1", 5'b00100, 2'd2);
        cyc(1, 0, 1, 0, 0, 0, 0, 0, 0, 0); dchk("rw_stall", 5'b11001, 2'd2);
        cyc(1, 0, 1, 0, 0, 0, 0, 0, 0, 0); dchk("rw_stall2", 5'b11001, 2'd1);
        cyc(1, 0, 1, 1, 0, 0, 0, 0, 0, 0); dchk("rw_ready", 5'b00000, 2'd1);
        idle(); dchk("rw_bub2", 5'b00100, 2'd2);
        idle(); dchk("rw_done", 5'b00000, 2'd0);

        // Reset asserted during MEM_WAIT aborts the wait.
        cyc(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 0, 0, 0, 0, 0, 0); dchk("rst_mw_pre", 5'b11001, 2'd1);
        cyc(0, 0, 1, 0, 0, 0, 0, 0, 0, 0); dchk("rst_mw_hold", 5'b00000, 2'd0);
        idle(); dchk("rst_mw_after", 5'b00000, 2'd0);
`ifdef HAZARD_PERF_EN
        check("perf_lu_rst", perf_lu_cnt, 32'd0);
        check("perf_br_rst", perf_br_cnt, 32'd0);
        check("perf_mw_rst", perf_mw_cnt, 32'd0);
        cyc(1, 0, 0, 0, 1, 5, 0, 5, 0, 1);
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        idle();
        check("perf_lu_1", perf_lu_cnt, 32'd1);
        check("perf_br_1", perf_br_cnt, 32'd1);
        check("perf_mw_1", perf_mw_cnt, 32'd1);
`endif
        idle(); idle();
        @(posedge clk);
        #1;
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
